zap_fetch_sched: RTL and testbench

Credit-based instruction-fetch scheduler sitting in front of the fetch FIFO. It issues sequential word fetches on a request/ack instruction bus, tracks bus requests in flight plus FIFO occupancy so the FIFO can never overflow, and writes in-order responses into the FIFO. On a pipeline redirect it restarts fetching at the new PC immediately and discards every stale response still returning from the bus.

---
 rtl/zap_fetch_sched_if.sv | 37 +++
 rtl/zap_fetch_sched.sv | 181 ++++++++++++++++++
 tb/tb_zap_fetch_sched.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zap_fetch_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : zap_fetch_sched_if
// Purpose  : Instruction-bus bundle between the fetch scheduler (master) and
//            the instruction memory port (slave). Request/ack handshake plus
//            an in-order read-response channel.
// Signals  : o_req       - fetch request valid (master -> slave)
//            o_addr      - word-aligned fetch address (master -> slave)
//            i_ack       - request accepted this cycle (slave -> master)
//            i_rsp_valid - in-order read response valid (slave -> master)
//            i_rsp_data  - read response data (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface zap_fetch_sched_if;
    logic        o_req;
    logic [31:0] o_addr;
    logic        i_ack;
    logic        i_rsp_valid;
    logic [31:0] i_rsp_data;

    modport master (
        output o_req,
        output o_addr,
        input  i_ack,
        input  i_rsp_valid,
        input  i_rsp_data
    );

    modport slave (
        input  o_req,
        input  o_addr,
        output i_ack,
        output i_rsp_valid,
        output i_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/zap_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : zap_fetch_sched
// Purpose  : Credit-based instruction-fetch scheduler in front of the fetch
//            FIFO. Issues sequential word fetches, reserves one FIFO slot per
//            request in flight so the FIFO can never overflow, writes in-order
//            responses straight into the FIFO and, on a redirect, restarts at
//            the new PC while discarding the stale responses still returning.
// Params   : DEPTH    - fetch FIFO entries
//            MAX_OUT  - max bus requests in flight (1 <= MAX_OUT <= DEPTH)
//            RESET_PC - first fetch address after reset (word aligned)
// Ports    : i_clk, i_reset_n        - clock, async active-low reset
//            i_redirect/_pc          - flush pulse and new fetch PC
//            i_stall                 - inhibit new requests
//            bus (master)            - instruction bus request/response
//            o_fifo_wr/o_fifo_data   - FIFO write port (combinational)
//            i_fifo_pop              - FIFO entry consumed
//            o_busy                  - request pending or responses owed
// Revision : 1.0 - initial release
// ============================================================================
module zap_fetch_sched #(
    parameter int          DEPTH    = 8,
    parameter int          MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    input  logic              i_stall,
    zap_fetch_sched_if.master bus,
    output logic              o_fifo_wr,
    output logic [31:0]       o_fifo_data,
    input  logic              i_fifo_pop,
    output logic              o_busy
);

    localparam int c_occ_w = $clog2(DEPTH + 1);
    localparam int c_inf_w = $clog2(MAX_OUT + 1);
    // occ + inflight can reach 2*DEPTH transiently in the comparison
    localparam int c_sum_w = c_occ_w + 1;

    localparam logic [c_sum_w-1:0] c_depth   = c_sum_w'(DEPTH);
    localparam logic [c_inf_w-1:0] c_max_out = c_inf_w'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [31:0]          r_next_pc;
    logic [31:0]          r_addr;
    logic [c_occ_w-1:0]   r_occ;
    logic [c_inf_w-1:0]   r_inflight;
    logic [c_inf_w-1:0]   r_drop;
    logic                 r_stale;

    logic                 w_req;
    logic                 w_launch;
    logic                 w_acked;
    logic                 w_rsp_ok;
    logic                 w_pop_ok;
    logic                 w_credit_ok;
    logic                 w_can_issue;
    logic [c_sum_w-1:0]   w_committed;
    logic                 w_unused_pc_lsbs;

    // Address bits [1:0] of a redirect are forced to zero.
    assign w_unused_pc_lsbs = ^i_redirect_pc[1:0];

    // Every FIFO slot is either filled or reserved by a request in flight.
    assign w_committed = {1'b0, r_occ} + c_sum_w'(r_inflight);
    assign w_credit_ok = (w_committed < c_depth) && (r_inflight < c_max_out);
    assign w_can_issue = !i_stall && !i_redirect && w_credit_ok;

    assign w_acked  = w_req && bus.i_ack;
    // A response with nothing outstanding is a protocol error: ignore it.
    assign w_rsp_ok = bus.i_rsp_valid && (r_inflight != '0);
    assign w_pop_ok = i_fifo_pop && (r_occ != '0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and request outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_can_issue) begin
                    w_state_nxt = S_REQ;
                    w_launch    = 1'b1;
                end
            end
            S_REQ: begin
                // A request is never withdrawn, not even by a redirect.
                w_req = 1'b1;
                if (bus.i_ack) begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: PC, credit counters, stale-response bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_next_pc  <= RESET_PC;
            r_addr     <= RESET_PC;
            r_occ      <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_stale    <= 1'b0;
        end else begin
            r_inflight <= r_inflight + c_inf_w'(w_acked) - c_inf_w'(w_rsp_ok);

            if (w_launch) begin
                r_addr <= r_next_pc;
            end

            if (i_redirect) begin
                r_next_pc <= {i_redirect_pc[31:2], 2'b00};
                r_occ     <= '0;
                // Everything still owed by the bus is now stale, including a
                // request accepted in this very cycle; the response arriving
                // now is discarded on the spot.
                r_drop    <= r_inflight + c_inf_w'(w_acked) - c_inf_w'(w_rsp_ok);
                // A pending request cannot be withdrawn, so remember that its
                // response must be dropped once it is accepted.
                if (r_state == S_REQ) begin
                    r_stale <= !bus.i_ack;
                end
            end else begin
                if (w_acked && !r_stale) begin
                    r_next_pc <= r_next_pc + 32'd4;
                end
                if (w_acked) begin
                    r_stale <= 1'b0;
                end
                r_drop <= r_drop + c_inf_w'(w_acked && r_stale)
                                 - c_inf_w'(w_rsp_ok && (r_drop != '0));
                r_occ  <= r_occ + c_occ_w'(o_fifo_wr) - c_occ_w'(w_pop_ok);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_req  = w_req;
    assign bus.o_addr = r_addr;

    assign o_fifo_wr   = w_rsp_ok && (r_drop == '0) && !i_redirect;
    assign o_fifo_data = bus.i_rsp_data;
    assign o_busy      = w_req || (r_inflight != '0);

endmodule
`default_nettype wire

// File: tb/tb_zap_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_zap_fetch_sched
// Purpose  : Directed self-checking bench for zap_fetch_sched. A small bus
//            model acknowledges requests and returns data = addr ^ c_mask
//            a fixed number of cycles after each ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zap_fetch_sched;

    localparam logic [31:0] c_rst_pc = 32'h0000_0100;
    localparam logic [31:0] c_mask   = 32'hCAFE_0000;
    localparam logic [31:0] c_none   = 32'hDEAD_BEEF;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    logic        clk;
    logic        i_reset_n;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall;
    logic        o_fifo_wr;
    logic [31:0] o_fifo_data;
    logic        i_fifo_pop;
    logic        o_busy;

    zap_fetch_sched_if bus ();

    zap_fetch_sched #(
        .DEPTH    (8),
        .MAX_OUT  (4),
        .RESET_PC (c_rst_pc)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall       (i_stall),
        .bus           (bus.master),
        .o_fifo_wr     (o_fifo_wr),
        .o_fifo_data   (o_fifo_data),
        .i_fifo_pop    (i_fifo_pop),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          lat;
    logic        auto_ack;
    logic        last_wr;
    pend_t       pq[$];
    logic [31:0] wr_log[$];
    logic [31:0] ack_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return c_none;
    endfunction

    function automatic logic [31:0] ack_at(input int i);
        if (i < ack_log.size()) return ack_log[i];
        return c_none;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick();
        bus.i_ack       = auto_ack && bus.o_req;
        bus.i_rsp_valid = 1'b0;
        bus.i_rsp_data  = '0;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            bus.i_rsp_valid = 1'b1;
            bus.i_rsp_data  = pq[0].addr ^ c_mask;
            void'(pq.pop_front());
        end
        #1;
        last_wr = o_fifo_wr;
        if (o_fifo_wr) wr_log.push_back(o_fifo_data);
        if (bus.i_ack) begin
            ack_log.push_back(bus.o_addr);
            pq.push_back('{due: cyc + lat, addr: bus.o_addr});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        i_reset_n       = 1'b0;
        i_redirect      = 1'b0;
        i_redirect_pc   = '0;
        i_stall         = 1'b0;
        i_fifo_pop      = 1'b0;
        bus.i_ack       = 1'b0;
        bus.i_rsp_valid = 1'b0;
        bus.i_rsp_data  = '0;
        pq.delete();
        wr_log.delete();
        ack_log.delete();
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_req"},  32'(bus.o_req), 32'd0);
        chk({tag, "_addr"}, bus.o_addr,     c_rst_pc);
        chk({tag, "_wr"},   32'(o_fifo_wr), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy),    32'd0);
        i_reset_n = 1'b1;
        cyc       = 0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 3;
        auto_ack = 1'b1;
        last_wr  = 1'b0;

        // ---------------- sequential fetch, then credit stall ----------------
        do_reset("rst1");
        lat = 3; auto_ack = 1'b1;
        tick();
        chk("first_req_early", 32'(bus.o_req), 32'd0);
        tick();
        chk("first_req",      32'(bus.o_req), 32'd1);
        chk("first_req_addr", bus.o_addr,     c_rst_pc);
        repeat (38) tick();
        chk("credit_acks",   32'(ack_log.size()), 32'd8);
        chk("credit_writes", 32'(wr_log.size()),  32'd8);
        chk("credit_req",    32'(bus.o_req),      32'd0);
        chk("credit_occ",    32'(dut.r_occ),      32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("seq_addr%0d", k), ack_at(k), c_rst_pc + 32'(4 * k));
            chk($sformatf("seq_data%0d", k), wr_at(k), (c_rst_pc + 32'(4 * k)) ^ c_mask);
        end
        i_fifo_pop = 1'b1;
        tick();
        i_fifo_pop = 1'b0;
        repeat (12) tick();
        chk("pop_one_ack",   32'(ack_log.size()), 32'd9);
        chk("pop_ack_addr",  ack_at(8),           32'h0000_0120);
        chk("pop_one_write", wr_at(8),            32'h0000_0120 ^ c_mask);

        // ---------------- redirect with 3 in flight ----------------
        do_reset("rst2");
        lat = 10; auto_ack = 1'b1;
        repeat (7) tick();
        chk("redir3_inflight", 32'(ack_log.size()), 32'd3);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_2003;
        tick();
        i_redirect = 1'b0;
        chk("redir3_no_req_n1", 32'(bus.o_req), 32'd0);
        tick();
        chk("redir3_req_n2",  32'(bus.o_req), 32'd1);
        chk("redir3_addr_n2", bus.o_addr,     32'h0000_2000);
        repeat (20) tick();
        chk("redir3_ack_addr", ack_at(3), 32'h0000_2000);
        chk("redir3_first_wr", wr_at(0),  32'h0000_2000 ^ c_mask);

        // ---------------- redirect while request pending ----------------
        do_reset("rst3");
        lat = 2; auto_ack = 1'b0;
        repeat (3) tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_3000;
        tick();
        i_redirect = 1'b0;
        chk("pend_req_held",  32'(bus.o_req), 32'd1);
        chk("pend_addr_held", bus.o_addr,     c_rst_pc);
        auto_ack = 1'b1;
        repeat (10) tick();
        chk("pend_ack0",     ack_at(0), c_rst_pc);
        chk("pend_ack1",     ack_at(1), 32'h0000_3000);
        chk("pend_first_wr", wr_at(0),  32'h0000_3000 ^ c_mask);

        // ---------------- redirect + response + pop together ----------------
        do_reset("rst4");
        lat = 3; auto_ack = 1'b1;
        repeat (7) tick();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_4000;
        i_fifo_pop    = 1'b1;
        tick();
        i_redirect = 1'b0;
        i_fifo_pop = 1'b0;
        chk("sim_no_write", 32'(last_wr),        32'd0);
        chk("sim_wr_count", 32'(wr_log.size()),  32'd1);
        chk("sim_occ",      32'(dut.r_occ),      32'd0);
        chk("sim_drop",     32'(dut.r_drop),     32'd1);
        repeat (10) tick();
        chk("sim_new_ack", ack_at(3), 32'h0000_4000);
        chk("sim_new_wr",  wr_at(1),  32'h0000_4000 ^ c_mask);

        // ---------------- async reset with 2 in flight ----------------
        do_reset("rst5");
        lat = 5; auto_ack = 1'b1;
        repeat (6) tick();
        chk("arst_busy_before", 32'(o_busy), 32'd1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_req",  32'(bus.o_req), 32'd0);
        chk("arst_addr", bus.o_addr,     c_rst_pc);
        chk("arst_busy", 32'(o_busy),    32'd0);
        wr_log.delete();
        ack_log.delete();
        tick();
        i_reset_n = 1'b1;
        repeat (4) tick();
        chk("arst_late_ignored", 32'(wr_log.size()), 32'd0);
        repeat (6) tick();
        chk("arst_new_ack", ack_at(0), c_rst_pc);
        chk("arst_new_wr",  wr_at(0),  c_rst_pc ^ c_mask);

        // ---------------- stall ----------------
        do_reset("rst6");
        lat = 2; auto_ack = 1'b0;
        repeat (2) tick();
        i_stall = 1'b1;
        repeat (2) tick();
        chk("stall_pending_req",  32'(bus.o_req), 32'd1);
        chk("stall_pending_addr", bus.o_addr,     c_rst_pc);
        auto_ack = 1'b1;
        repeat (8) tick();
        chk("stall_one_ack", 32'(ack_log.size()), 32'd1);
        chk("stall_no_req",  32'(bus.o_req),      32'd0);
        chk("stall_wr",      wr_at(0),            c_rst_pc ^ c_mask);
        i_stall = 1'b0;
        repeat (4) tick();
        chk("unstall_ack", ack_at(1), c_rst_pc + 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
